// File: rtl/aes_fifo_pkg.sv
// aes_fifo_pkg: word/block widths and types shared by the AES FIFOs and round core
package aes_fifo_pkg;
  localparam int WORD_W = 32;
  localparam int BLOCK_W = 128;
  localparam int WORDS_PER_BLK = 4;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/fifo_out_if.sv
// fifo_out_if: block-write / word-read bus of the output FIFO; FIFO_OUT_ERR_EN adds sticky error flags and their clear
interface fifo_out_if #(parameter int DEPTH = 2);
  import aes_fifo_pkg::*;
  localparam int CW = $clog2(4 * DEPTH) + 1;
  logic write_en;
  block_t data_in;
  logic read_en;
  word_t data_out;
  logic fifo_empty;
  logic fifo_full;
  logic [CW-1:0] words_avail;
`ifdef FIFO_OUT_ERR_EN
  logic err_clr;
  logic overflow;
  logic underflow;
  modport master (output write_en, data_in, read_en, err_clr,
                  input data_out, fifo_empty, fifo_full, words_avail, overflow, underflow);
  modport slave (input write_en, data_in, read_en, err_clr,
                 output data_out, fifo_empty, fifo_full, words_avail, overflow, underflow);
`else
  modport master (output write_en, data_in, read_en,
                  input data_out, fifo_empty, fifo_full, words_avail);
  modport slave (input write_en, data_in, read_en,
                 output data_out, fifo_empty, fifo_full, words_avail);
`endif
endinterface

// File: rtl/fifo_out_store.sv
// fifo_out_store: DEPTH-entry block register array, one write port and one combinational read port
module fifo_out_store
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  block_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output block_t                   rdata
);
  block_t mem [DEPTH];
  // block contents are left in place on pop and across reset; only pointers track validity
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // head block presented combinationally for the word mux
  always_comb rdata = mem[raddr];
endmodule

// File: rtl/fifo_out.sv
// fifo_out: buffers DEPTH 128-bit blocks and serialises them MSW-first as 32-bit words; FIFO_OUT_ERR_EN adds overflow/underflow flags
module fifo_out
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic       clk,
  input logic       n_rst,
  fifo_out_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(4 * DEPTH) + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [1:0] word_idx, word_nxt;
  logic [BW-1:0] blk_cnt, blk_nxt;
  logic wr_acc, rd_acc, pop;
  block_t head;
  fifo_out_store #(.DEPTH(DEPTH)) u_store (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(bus.data_in),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // acceptance uses the registered start-of-cycle flags, so a write while full is dropped even if this cycle frees a slot
  always_comb begin
    wr_acc = bus.write_en && !bus.fifo_full;
    rd_acc = bus.read_en && !bus.fifo_empty;
    pop = rd_acc && word_idx == 2'd3;
    blk_nxt = blk_cnt + BW'(wr_acc) - BW'(pop);
    word_nxt = word_idx + 2'(rd_acc);
  end
  // pointers, counters, popped word and flags; flags are registered from next-state so they track blk_cnt exactly
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      word_idx <= '0;
      blk_cnt <= '0;
      bus.data_out <= '0;
      bus.fifo_empty <= 1'b1;
      bus.fifo_full <= 1'b0;
      bus.words_avail <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      word_idx <= word_nxt;
      blk_cnt <= blk_nxt;
      if (rd_acc) bus.data_out <= head[{~word_idx, 5'b0} +: WORD_W];
      bus.fifo_empty <= blk_nxt == '0;
      bus.fifo_full <= blk_nxt == BW'(DEPTH);
      bus.words_avail <= CW'({blk_nxt, 2'b00}) - CW'(word_nxt);
    end
`ifdef FIFO_OUT_ERR_EN
  // sticky error flags; a same-cycle set beats err_clr
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.overflow <= (bus.write_en && bus.fifo_full) ? 1'b1 : bus.err_clr ? 1'b0 : bus.overflow;
      bus.underflow <= (bus.read_en && bus.fifo_empty) ? 1'b1 : bus.err_clr ? 1'b0 : bus.underflow;
    end
`endif
endmodule

// File: tb/tb_fifo_out.sv
// tb_fifo_out: directed and randomized checks of fifo_out against a word-queue reference model
module tb_fifo_out;
  import aes_fifo_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int tests = 0;
  int fails = 0;
  word_t mq[$];
  word_t m_dout = '0;
  bit m_ovf = 0;
  bit m_unf = 0;
  fifo_out_if #(.DEPTH(DEPTH)) bus ();
  fifo_out #(.DEPTH(DEPTH)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic block_t rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // one clock with the given inputs; the model works on a plain queue of words
  task automatic step(input bit we, input block_t d, input bit re, input bit clr = 0);
    bit full0, emp0;
    block_t dv;
    full0 = (mq.size() + 3) / 4 == DEPTH;
    emp0 = mq.size() == 0;
    dv = d;
    bus.write_en = we;
    bus.data_in = d;
    bus.read_en = re;
`ifdef FIFO_OUT_ERR_EN
    bus.err_clr = clr;
`endif
    @(posedge clk);
    if (re && !emp0) m_dout = mq.pop_front();
    if (we && !full0) for (int i = 0; i < 4; i++) mq.push_back(dv[127-32*i -: 32]);
    if (we && full0) m_ovf = 1; else if (clr) m_ovf = 0;
    if (re && emp0) m_unf = 1; else if (clr) m_unf = 0;
    @(negedge clk);
    bus.write_en = 0;
    bus.read_en = 0;
`ifdef FIFO_OUT_ERR_EN
    bus.err_clr = 0;
`endif
  endtask
  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf = 0;
    m_unf = 0;
  endtask
  task automatic test_reset();
    bus.write_en = 0;
    bus.read_en = 0;
    bus.data_in = '0;
`ifdef FIFO_OUT_ERR_EN
    bus.err_clr = 0;
`endif
    n_rst = 0;
    repeat (2) @(negedge clk);
    model_reset();
    tests++; if (bus.data_out !== 32'h0) begin fails++; $display("FAIL reset_data_out got %h exp 0", bus.data_out); end
    tests++; if (bus.fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", bus.fifo_empty); end
    tests++; if (bus.fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", bus.fifo_full); end
    tests++; if (bus.words_avail !== 4'd0) begin fails++; $display("FAIL reset_avail got %0d exp 0", bus.words_avail); end
    n_rst = 1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    word_t exp_w[4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    step(1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0);
    tests++; if (bus.fifo_empty !== 1'b0) begin fails++; $display("FAIL basic_empty_after_wr got %b exp 0", bus.fifo_empty); end
    tests++; if (bus.words_avail !== 4'd4) begin fails++; $display("FAIL basic_avail_wr got %0d exp 4", bus.words_avail); end
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1);
      tests++; if (bus.data_out !== exp_w[i]) begin fails++; $display("FAIL basic_word%0d got %h exp %h", i, bus.data_out, exp_w[i]); end
      tests++; if (bus.words_avail !== 4'(3 - i)) begin fails++; $display("FAIL basic_avail%0d got %0d exp %0d", i, bus.words_avail, 3 - i); end
    end
    tests++; if (bus.fifo_empty !== 1'b1) begin fails++; $display("FAIL basic_empty_end got %b exp 1", bus.fifo_empty); end
  endtask
  task automatic test_full();
    block_t a = rnd_blk(), b = rnd_blk(), c = rnd_blk();
    word_t e;
    step(1, a, 0);
    tests++; if (bus.fifo_full !== 1'b0) begin fails++; $display("FAIL full_after_a got %b exp 0", bus.fifo_full); end
    step(1, b, 0);
    tests++; if (bus.fifo_full !== 1'b1) begin fails++; $display("FAIL full_after_b got %b exp 1", bus.fifo_full); end
    step(1, c, 0);
    tests++; if (bus.words_avail !== 4'd8) begin fails++; $display("FAIL full_drop_avail got %0d exp 8", bus.words_avail); end
`ifdef FIFO_OUT_ERR_EN
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL full_overflow got %b exp 1", bus.overflow); end
    step(0, '0, 0, 1);
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL overflow_clr got %b exp 0", bus.overflow); end
`endif
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1);
      e = i < 4 ? a[127-32*i -: 32] : b[127-32*(i-4) -: 32];
      tests++; if (bus.data_out !== e) begin fails++; $display("FAIL full_drain%0d got %h exp %h", i, bus.data_out, e); end
    end
    tests++; if (bus.fifo_empty !== 1'b1) begin fails++; $display("FAIL full_drain_empty got %b exp 1", bus.fifo_empty); end
  endtask
  task automatic test_simul_last_word();
    block_t e = rnd_blk(), d = rnd_blk();
    step(1, e, 0);
    repeat (3) step(0, '0, 1);
    step(1, d, 1);
    tests++; if (bus.data_out !== e[31:0]) begin fails++; $display("FAIL simul_w3 got %h exp %h", bus.data_out, e[31:0]); end
    tests++; if (bus.words_avail !== 4'd4) begin fails++; $display("FAIL simul_avail got %0d exp 4", bus.words_avail); end
    tests++; if (bus.fifo_empty !== 1'b0 || bus.fifo_full !== 1'b0) begin fails++; $display("FAIL simul_flags got e%b f%b exp e0 f0", bus.fifo_empty, bus.fifo_full); end
    step(0, '0, 1);
    tests++; if (bus.data_out !== d[127:96]) begin fails++; $display("FAIL simul_next got %h exp %h", bus.data_out, d[127:96]); end
    repeat (3) step(0, '0, 1);
    tests++; if (bus.data_out !== d[31:0] || bus.fifo_empty !== 1'b1) begin fails++; $display("FAIL simul_tail got %h e%b exp %h e1", bus.data_out, bus.fifo_empty, d[31:0]); end
  endtask
  task automatic test_full_simul();
    block_t f = rnd_blk(), g = rnd_blk(), h = rnd_blk();
    step(1, f, 0);
    step(1, g, 0);
    repeat (3) step(0, '0, 1);
    tests++; if (bus.fifo_full !== 1'b1) begin fails++; $display("FAIL fsim_full got %b exp 1", bus.fifo_full); end
    step(1, h, 1);
    tests++; if (bus.fifo_full !== 1'b0) begin fails++; $display("FAIL fsim_notfull got %b exp 0", bus.fifo_full); end
    tests++; if (bus.words_avail !== 4'd4) begin fails++; $display("FAIL fsim_avail got %0d exp 4", bus.words_avail); end
    tests++; if (bus.data_out !== f[31:0]) begin fails++; $display("FAIL fsim_w3 got %h exp %h", bus.data_out, f[31:0]); end
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1);
      tests++; if (bus.data_out !== g[127-32*i -: 32]) begin fails++; $display("FAIL fsim_g%0d got %h exp %h", i, bus.data_out, g[127-32*i -: 32]); end
    end
    tests++; if (bus.fifo_empty !== 1'b1) begin fails++; $display("FAIL fsim_empty got %b exp 1 (h must be dropped)", bus.fifo_empty); end
  endtask
  task automatic test_empty_read();
    word_t prev = m_dout;
    step(0, '0, 1);
    tests++; if (bus.data_out !== prev) begin fails++; $display("FAIL empty_rd_hold got %h exp %h", bus.data_out, prev); end
    tests++; if (bus.words_avail !== 4'd0) begin fails++; $display("FAIL empty_rd_avail got %0d exp 0", bus.words_avail); end
`ifdef FIFO_OUT_ERR_EN
    tests++; if (bus.underflow !== 1'b1) begin fails++; $display("FAIL underflow_set got %b exp 1", bus.underflow); end
    step(0, '0, 1, 1);
    tests++; if (bus.underflow !== 1'b1) begin fails++; $display("FAIL underflow_set_wins got %b exp 1", bus.underflow); end
    step(0, '0, 0, 1);
    tests++; if (bus.underflow !== 1'b0) begin fails++; $display("FAIL underflow_clr got %b exp 0", bus.underflow); end
`endif
  endtask
  task automatic test_mid_reset();
    block_t a = rnd_blk(), b = rnd_blk();
    step(1, a, 0);
    step(1, rnd_blk(), 0);
    repeat (2) step(0, '0, 1);
    #2 n_rst = 0;
    #1;
    model_reset();
    tests++; if (bus.data_out !== 32'h0 || bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0 || bus.words_avail !== 4'd0) begin
      fails++; $display("FAIL midrst_async got d%h e%b f%b a%0d exp d0 e1 f0 a0", bus.data_out, bus.fifo_empty, bus.fifo_full, bus.words_avail);
    end
    @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    step(1, b, 0);
    tests++; if (bus.words_avail !== 4'd4) begin fails++; $display("FAIL midrst_avail got %0d exp 4", bus.words_avail); end
    step(0, '0, 1);
    tests++; if (bus.data_out !== b[127:96]) begin fails++; $display("FAIL midrst_word0 got %h exp %h", bus.data_out, b[127:96]); end
    repeat (3) step(0, '0, 1);
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 2) != 0, rnd_blk(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      tests++;
      if (bus.data_out !== m_dout || bus.fifo_empty !== (mq.size() == 0) ||
          bus.fifo_full !== ((mq.size() + 3) / 4 == DEPTH) || bus.words_avail !== 4'(mq.size())) begin
        fails++;
        $display("FAIL rand%0d got d%h e%b f%b a%0d exp d%h e%b f%b a%0d", n, bus.data_out, bus.fifo_empty, bus.fifo_full,
                 bus.words_avail, m_dout, mq.size() == 0, (mq.size() + 3) / 4 == DEPTH, mq.size());
      end
`ifdef FIFO_OUT_ERR_EN
      tests++;
      if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
        fails++; $display("FAIL rand_err%0d got o%b u%b exp o%b u%b", n, bus.overflow, bus.underflow, m_ovf, m_unf);
      end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_simul_last_word();
    test_full_simul();
    test_empty_read();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
